spart_rx_packer: RTL and testbench
==================================

# spart_rx_packer

Receive-side word assembler between the SPART receiver and the processor datapath. Collects received bytes in pairs, high byte first (the same order the transmit path sends a 16-bit word), and packs each pair into a 16-bit word. Words go into a small first-word-fall-through FIFO. The processor drains the FIFO through the SPART source path into the register file.

## Interface
Parameters:
- DEPTH, 4: word FIFO entries; power of two, minimum 2.
- TIMEOUT, 1023: cycles to wait for a low byte before flushing a lone high byte (used only with SPART_RX_TIMEOUT_EN).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- rx_byte  input  8  received byte from SPART.
- rx_valid  input  1  one-cycle strobe; rx_byte valid this cycle.
- rd_en  input  1  pop head word; ignored while empty.
- rd_data  output  16  head word; 16'h0000 while empty.
- empty  output  1  FIFO holds no words.
- full  output  1  FIFO holds DEPTH words.
- count  output  $clog2(DEPTH)+1  words held.
- half  output  1  high byte latched, low byte pending.
- overflow  output  1  sticky; a completed word was dropped.
- clr_ovf  input  1  clears overflow.

## Operation
- Reset values: count 0, empty 1, full 0, half 0, overflow 0, rd_data 16'h0000. Read and write pointers are 0 and the state is HI.
- State HI:
  - On rx_valid, latch rx_byte as the high byte, set half, and go to LO.
- State LO:
  - On rx_valid, form the word {hi_byte, rx_byte}, attempt a push, clear half, and return to HI.
- Push rules:
  - A push succeeds if the FIFO is not full, or if it is full and rd_en is asserted the same cycle.
  - Otherwise the word is dropped and overflow is set. The state still returns to HI.
- Pop: rd_en with empty deasserted advances the read pointer. rd_data shows the next head word, or 16'h0000 if the FIFO is now empty.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is maintained separately; empty = (count==0) and full = (count==DEPTH).
- Push and pop in the same cycle with the FIFO non-empty: both occur, count is unchanged. When full, the freed slot receives the new word.
- Push and rd_en in the same cycle with the FIFO empty: rd_en is ignored and the push occurs.
- overflow: clr_ovf clears it. If clr_ovf and a drop occur in the same cycle, set wins.
- Reset mid-word discards the latched high byte. Reset mid-drain discards all FIFO contents.

## Timing
- rx_valid for the low byte sampled at edge k: the word is written at edge k, and empty falls / count increments after edge k. rd_data is valid in cycle k+1.
- rd_data is combinational from the head entry (show-ahead); no read latency.
- rd_en sampled at edge k: the pointer advances at edge k, and the new head appears in cycle k+1.
- half rises the cycle after the high byte is sampled and falls the cycle after the low byte is sampled.
- Back-to-back rx_valid every cycle is supported: one word every two cycles.

## Configuration
- SPART_RX_TIMEOUT_EN defined:
  - A counter clears on entry to LO and increments each cycle in LO without rx_valid.
  - When the count reaches TIMEOUT, push {8'h00, hi_byte} (same push/overflow rules), clear half, and return to HI.
  - If rx_valid arrives in the same cycle as the timeout, the rx_valid path wins: a normal word is formed.
- SPART_RX_TIMEOUT_EN undefined: no counter; LO waits indefinitely and TIMEOUT is unused.

## Test plan
- Basic pack: after reset, send bytes 8'hAB then 8'hCD -> rd_data=16'hABCD, count=1, empty=0. Pulse rd_en -> empty=1, rd_data=16'h0000.
- Ordering and wrap: send 6 words 16'h0001..16'h0006 with reads interleaved after every second word (DEPTH=4) -> words read back in order. The pointers wrap, and overflow stays 0.
- Full and overflow: push 4 words, then a 5th, 16'hBEEF -> full=1, overflow=1, and FIFO contents unchanged. Repeat the 5th push with rd_en in the same cycle -> the word is accepted and overflow is not newly set. Apply clr_ovf -> overflow=0.
- Simultaneous clear and drop: clr_ovf asserted in the same cycle as a dropped word -> overflow=1.
- Reset mid-word: send 8'h12, assert rst_n=0 for one cycle, then send 8'h34, 8'h56 -> rd_data=16'h3456, half=0 after the reset cycle.
- Timeout (SPART_RX_TIMEOUT_EN, TIMEOUT=8): send 8'h7F and wait 8 idle cycles -> rd_data=16'h007F, half=0. Without the macro -> half stays 1 and empty stays 1.

Source files
------------

// File: rtl/spart_rx_packer.sv
// spart_rx_packer: packs received byte pairs (high byte first) into 16-bit
// words and queues them in a show-ahead word FIFO for the processor.
// Optional feature macro: SPART_RX_TIMEOUT_EN flushes a lone high byte as
// {8'h00, hi} after TIMEOUT idle cycles in LO.
module spart_rx_packer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_valid,
  input  logic                    rd_en,
  output logic [15:0]             rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    half,
  output logic                    overflow,
  input  logic                    clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    ST_HI = 1'b0,
    ST_LO = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      hi_q, hi_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     mem_q [DEPTH];
  logic [15:0]     mem_d [DEPTH];

  logic            hi_load_c;
  logic            push_req_c;
  logic [15:0]     push_word_c;
  logic            push_ok_c;
  logic            drop_c;
  logic            pop_c;
  logic            tmo_fire_c;

`ifdef SPART_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0]   tmo_q, tmo_d;

  // Idle counter: held at zero outside LO, fires on the TIMEOUT-th idle cycle.
  always_comb begin
    tmo_d      = tmo_q;
    tmo_fire_c = 1'b0;
    if (state_q == ST_HI || rx_valid) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
      tmo_fire_c = 1'b1;
      tmo_d      = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;

  assign tmo_fire_c     = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_HI;
    else        state_q <= state_d;
  end

  // Next state: a byte moves HI->LO; a byte or a timeout flush returns to HI.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HI:   if (rx_valid) state_d = ST_LO;
      ST_LO:   if (rx_valid || tmo_fire_c) state_d = ST_HI;
      default: state_d = ST_HI;
    endcase
  end

  // FSM outputs: high-byte latch, push request and the word to push.
  always_comb begin
    hi_load_c   = 1'b0;
    push_req_c  = 1'b0;
    push_word_c = {hi_q, rx_byte};
    half        = 1'b0;
    case (state_q)
      ST_HI: begin
        hi_load_c = rx_valid;
      end
      ST_LO: begin
        half = 1'b1;
        if (rx_valid) begin
          push_req_c = 1'b1;
        end else if (tmo_fire_c) begin
          push_req_c  = 1'b1;
          push_word_c = {8'h00, hi_q};
        end
      end
      default: ;
    endcase
  end

  // FIFO datapath: a full FIFO still accepts a push when rd_en frees the head.
  always_comb begin
    pop_c     = rd_en && (count_q != '0);
    push_ok_c = push_req_c && (!full || rd_en);
    drop_c    = push_req_c && !push_ok_c;

    hi_d     = hi_load_c ? rx_byte : hi_q;
    wr_ptr_d = push_ok_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok_c) - CW'(pop_c);

    mem_d = mem_q;
    if (push_ok_c) mem_d[wr_ptr_q] = push_word_c;

    ovf_d = ovf_q;
    if (drop_c)       ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // Datapath registers; reset discards any latched byte and all queued words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      hi_q     <= hi_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  // Status decode and show-ahead head word.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    count    = count_q;
    overflow = ovf_q;
    rd_data  = empty ? 16'h0000 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_spart_rx_packer.sv
// Self-checking bench for spart_rx_packer: directed vector table, hand
// sequences for wrap/timeout, then random traffic against a queue model.
module tb_spart_rx_packer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        half;
  logic        overflow;
  logic        clr_ovf;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [15:0] m_q[$];
  bit          m_pend;
  logic [7:0]  m_hi;
  bit          m_ovf;
  int          m_idle;

  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  b;
    logic        rd;
    logic        clr;
    logic [15:0] d;
    logic [2:0]  cnt;
    logic        e;
    logic        f;
    logic        h;
    logic        o;
  } vec_t;

  vec_t vecs[$];

  spart_rx_packer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .half     (half),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural model: queue of words plus pending-byte bookkeeping.
  task automatic model_step(input logic r, input logic v, input logic [7:0] b,
                            input logic rd, input logic clr);
    bit push;
    bit drop;
    logic [15:0] w;
    push = 0;
    drop = 0;
    w    = '0;
    if (!r) begin
      m_q.delete();
      m_pend = 0;
      m_ovf  = 0;
      m_idle = 0;
      return;
    end
    if (m_pend && v) begin
      w = {m_hi, b};
      push = 1;
      m_pend = 0;
    end else if (!m_pend && v) begin
      m_hi   = b;
      m_pend = 1;
      m_idle = 0;
    end else if (m_pend) begin
`ifdef SPART_RX_TIMEOUT_EN
      m_idle++;
      if (m_idle == int'(TIMEOUT)) begin
        w = {8'h00, m_hi};
        push = 1;
        m_pend = 0;
      end
`endif
    end
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < int'(DEPTH)) m_q.push_back(w);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  // Apply one cycle of inputs, advance the model, and settle past the edge.
  task automatic cycle(input logic r, input logic v, input logic [7:0] b,
                       input logic rd, input logic clr);
    rst_n = r; rx_valid = v; rx_byte = b; rd_en = rd; clr_ovf = clr;
    model_step(r, v, b, rd, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] d, input logic [2:0] cnt,
                           input logic e, input logic f, input logic h, input logic o);
    chk({tag, ".rd_data"},  32'(rd_data),  32'(d));
    chk({tag, ".count"},    32'(count),    32'(cnt));
    chk({tag, ".empty"},    32'(empty),    32'(e));
    chk({tag, ".full"},     32'(full),     32'(f));
    chk({tag, ".half"},     32'(half),     32'(h));
    chk({tag, ".overflow"}, 32'(overflow), 32'(o));
  endtask

  task automatic check_model(input string tag);
    logic [15:0] d;
    d = (m_q.size() > 0) ? m_q[0] : 16'h0000;
    check_all(tag, d, 3'(m_q.size()), m_q.size() == 0, m_q.size() == int'(DEPTH),
              m_pend, m_ovf);
  endtask

  function automatic vec_t mk(logic r, logic v, logic [7:0] b, logic rd, logic clr,
                              logic [15:0] d, logic [2:0] cnt, logic e, logic f,
                              logic h, logic o);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.rd = rd; t.clr = clr;
    t.d = d; t.cnt = cnt; t.e = e; t.f = f; t.h = h; t.o = o;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    m_pend = 0; m_hi = '0; m_ovf = 0; m_idle = 0;

    // Directed vectors: inputs for one cycle, expected outputs after that edge.
    vecs.push_back(mk(0,0,8'h00,0,0, 16'h0000,0,1,0,0,0)); // reset
    vecs.push_back(mk(1,1,8'hAB,0,0, 16'h0000,0,1,0,1,0));
    vecs.push_back(mk(1,1,8'hCD,0,0, 16'hABCD,1,0,0,0,0)); // basic pack
    vecs.push_back(mk(1,0,8'h00,1,0, 16'h0000,0,1,0,0,0)); // pop to empty
    vecs.push_back(mk(1,0,8'h00,1,0, 16'h0000,0,1,0,0,0)); // rd_en on empty
    vecs.push_back(mk(1,1,8'h11,0,0, 16'h0000,0,1,0,1,0));
    vecs.push_back(mk(1,1,8'h11,0,0, 16'h1111,1,0,0,0,0));
    vecs.push_back(mk(1,1,8'h22,0,0, 16'h1111,1,0,0,1,0));
    vecs.push_back(mk(1,1,8'h22,0,0, 16'h1111,2,0,0,0,0));
    vecs.push_back(mk(1,1,8'h33,0,0, 16'h1111,2,0,0,1,0));
    vecs.push_back(mk(1,1,8'h33,0,0, 16'h1111,3,0,0,0,0));
    vecs.push_back(mk(1,1,8'h44,0,0, 16'h1111,3,0,0,1,0));
    vecs.push_back(mk(1,1,8'h44,0,0, 16'h1111,4,0,1,0,0)); // full
    vecs.push_back(mk(1,1,8'hBE,0,0, 16'h1111,4,0,1,1,0));
    vecs.push_back(mk(1,1,8'hEF,0,0, 16'h1111,4,0,1,0,1)); // dropped
    vecs.push_back(mk(1,1,8'hBE,0,0, 16'h1111,4,0,1,1,1));
    vecs.push_back(mk(1,1,8'hEF,1,0, 16'h2222,4,0,1,0,1)); // push+pop while full
    vecs.push_back(mk(1,0,8'h00,0,1, 16'h2222,4,0,1,0,0)); // clr_ovf
    vecs.push_back(mk(1,1,8'h55,0,0, 16'h2222,4,0,1,1,0));
    vecs.push_back(mk(1,1,8'h66,0,1, 16'h2222,4,0,1,0,1)); // drop beats clear
    vecs.push_back(mk(1,0,8'h00,1,0, 16'h3333,3,0,0,0,1));
    vecs.push_back(mk(1,0,8'h00,1,0, 16'h4444,2,0,0,0,1));
    vecs.push_back(mk(1,0,8'h00,1,0, 16'hBEEF,1,0,0,0,1));
    vecs.push_back(mk(1,0,8'h00,1,0, 16'h0000,0,1,0,0,1));
    vecs.push_back(mk(1,0,8'h00,0,1, 16'h0000,0,1,0,0,0));
    vecs.push_back(mk(1,1,8'h77,0,0, 16'h0000,0,1,0,1,0));
    vecs.push_back(mk(1,1,8'h88,0,0, 16'h7788,1,0,0,0,0));
    vecs.push_back(mk(1,1,8'h99,1,0, 16'h0000,0,1,0,1,0));
    vecs.push_back(mk(1,1,8'hAA,1,0, 16'h99AA,1,0,0,0,0)); // rd_en ignored when empty
    vecs.push_back(mk(1,1,8'hBB,0,0, 16'h99AA,1,0,0,1,0));
    vecs.push_back(mk(1,1,8'hCC,1,0, 16'hBBCC,1,0,0,0,0)); // push+pop non-empty
    vecs.push_back(mk(1,1,8'h12,0,0, 16'hBBCC,1,0,0,1,0));
    vecs.push_back(mk(0,0,8'h00,0,0, 16'h0000,0,1,0,0,0)); // reset mid-word
    vecs.push_back(mk(1,1,8'h34,0,0, 16'h0000,0,1,0,1,0));
    vecs.push_back(mk(1,1,8'h56,0,0, 16'h3456,1,0,0,0,0));
    vecs.push_back(mk(1,0,8'h00,1,0, 16'h0000,0,1,0,0,0));

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].b, vecs[i].rd, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].cnt, vecs[i].e,
                vecs[i].f, vecs[i].h, vecs[i].o);
    end

    // Ordering and pointer wrap: six words, two reads after every second word.
    for (int i = 1; i <= 6; i++) begin
      logic [15:0] w;
      w = 16'(i);
      cycle(1, 1, w[15:8], 0, 0);
      cycle(1, 1, w[7:0], 0, 0);
      if (i % 2 == 0) begin
        chk($sformatf("wrap%0d.first", i), 32'(rd_data), 32'(i - 1));
        cycle(1, 0, 8'h00, 1, 0);
        chk($sformatf("wrap%0d.second", i), 32'(rd_data), 32'(i));
        cycle(1, 0, 8'h00, 1, 0);
        chk($sformatf("wrap%0d.empty", i), 32'(empty), 32'(1));
      end
    end
    chk("wrap.overflow", 32'(overflow), 32'(0));

    // Lone high byte: still pending after TIMEOUT-1 idle cycles.
    cycle(1, 1, 8'h7F, 0, 0);
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) cycle(1, 0, 8'h00, 0, 0);
    check_all("tmo.before", 16'h0000, 0, 1, 0, 1, 0);
    cycle(1, 0, 8'h00, 0, 0);
`ifdef SPART_RX_TIMEOUT_EN
    check_all("tmo.fire", 16'h007F, 1, 0, 0, 0, 0);
    cycle(1, 0, 8'h00, 1, 0);
`else
    check_all("tmo.none", 16'h0000, 0, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) cycle(1, 0, 8'h00, 0, 0);
    check_all("tmo.still", 16'h0000, 0, 1, 0, 1, 0);
    cycle(1, 1, 8'h80, 0, 0);
    check_all("tmo.late", 16'h7F80, 1, 0, 0, 0, 0);
    cycle(1, 0, 8'h00, 1, 0);
`endif
    check_model("sync");

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic r;
      logic v;
      logic rd;
      logic clr;
      r   = ($urandom_range(199, 0) != 0);
      v   = ($urandom_range(99, 0) < 55);
      rd  = ($urandom_range(99, 0) < 30);
      clr = ($urandom_range(99, 0) < 5);
      cycle(r, v, 8'($urandom), rd, clr);
      check_model($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
